// File: rtl/atm_auth_responder.sv
// atm_auth_responder: PIN verification, withdrawal approval and balance keeping for one ATM account
module atm_auth_responder #(
  parameter logic [15:0] PIN_CODE     = 16'h1234,
  parameter logic [15:0] INIT_BALANCE = 16'd1000,
  parameter logic [1:0]  MAX_TRIES    = 2'd3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        card_inserted,
  input  logic        digit_valid,
  input  logic [3:0]  digit,
  input  logic        amount_valid,
  input  logic [15:0] amount,
  input  logic        dispense_cash,
  output logic        pin_correct,
  output logic        balance_ok,
  output logic        card_locked,
  output logic        amount_reject,
  output logic [15:0] balance
);
  typedef enum logic [2:0] {IDLE, PIN_ENTRY, PIN_OK, AMT_OK, LOCKED} state_t;
  state_t state, n_state;
  logic [15:0] pin_reg, n_pin, amt, n_amt, n_bal, shifted;
  logic [2:0]  cnt, n_cnt;
  logic [1:0]  fails, n_fails;
  logic        n_rej;
  // Session state, counters and registered flags; reset discards any pending amount
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      pin_reg       <= '0;
      cnt           <= '0;
      fails         <= '0;
      amt           <= '0;
      balance       <= INIT_BALANCE;
      amount_reject <= 1'b0;
      pin_correct   <= 1'b0;
      balance_ok    <= 1'b0;
      card_locked   <= 1'b0;
    end else begin
      state         <= n_state;
      pin_reg       <= n_pin;
      cnt           <= n_cnt;
      fails         <= n_fails;
      amt           <= n_amt;
      balance       <= n_bal;
      amount_reject <= n_rej;
      pin_correct   <= (n_state == PIN_OK) || (n_state == AMT_OK);
      balance_ok    <= n_state == AMT_OK;
      card_locked   <= n_state == LOCKED;
    end
  end
  // Next-state logic; the fail counter survives card removal so lockout spans sessions
  always_comb begin
    n_state = state;
    n_pin   = pin_reg;
    n_cnt   = cnt;
    n_fails = fails;
    n_amt   = amt;
    n_bal   = balance;
    n_rej   = 1'b0;
    shifted = {pin_reg[11:0], digit};
    case (state)
      IDLE: if (card_inserted) begin
        n_state = PIN_ENTRY;
        n_cnt   = '0;
        n_pin   = '0;
      end
      PIN_ENTRY: begin
        if (!card_inserted) n_state = IDLE;
        else if (digit_valid && digit <= 4'd9) begin
          if (cnt == 3'd3) begin
            n_cnt = '0;
            n_pin = '0;
            if (shifted == PIN_CODE) begin
              n_state = PIN_OK;
              n_fails = '0;
            end else begin
              n_fails = fails + 2'd1;
              if (n_fails == MAX_TRIES) n_state = LOCKED;
            end
          end else begin
            n_pin = shifted;
            n_cnt = cnt + 3'd1;
          end
        end
      end
      PIN_OK: begin
        if (!card_inserted) n_state = IDLE;
        else if (amount_valid) begin
          if (amount != 16'd0 && amount <= balance) begin
            n_amt   = amount;
            n_state = AMT_OK;
          end else n_rej = 1'b1;
        end
      end
      AMT_OK: begin
        if (dispense_cash) begin
          n_bal   = (amt <= balance) ? balance - amt : balance;
          n_state = IDLE;
        end else if (!card_inserted) n_state = IDLE;
      end
      LOCKED: n_state = LOCKED;
      default: n_state = IDLE;
    endcase
  end
endmodule

// File: tb/tb_atm_auth_responder.sv
// tb_atm_auth_responder: directed scenario checks of the ATM authorisation responder
module tb_atm_auth_responder;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        card_inserted = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = '0;
  logic        amount_valid = 1'b0;
  logic [15:0] amount = '0;
  logic        dispense_cash = 1'b0;
  logic        pin_correct, balance_ok, card_locked, amount_reject;
  logic [15:0] balance;
  int checks = 0;
  int errors = 0;

  atm_auth_responder dut (
    .clk(clk), .rst_n(rst_n), .card_inserted(card_inserted),
    .digit_valid(digit_valid), .digit(digit), .amount_valid(amount_valid),
    .amount(amount), .dispense_cash(dispense_cash), .pin_correct(pin_correct),
    .balance_ok(balance_ok), .card_locked(card_locked),
    .amount_reject(amount_reject), .balance(balance)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    card_inserted = 1'b0;
    digit_valid   = 1'b0;
    amount_valid  = 1'b0;
    dispense_cash = 1'b0;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic send_digit(input logic [3:0] d);
    digit_valid = 1'b1;
    digit = d;
    step();
    digit_valid = 1'b0;
  endtask

  task automatic enter_pin(input logic [15:0] p);
    card_inserted = 1'b1;
    step();
    send_digit(p[15:12]);
    send_digit(p[11:8]);
    send_digit(p[7:4]);
    send_digit(p[3:0]);
  endtask

  task automatic send_amount(input logic [15:0] a);
    amount_valid = 1'b1;
    amount = a;
    step();
    amount_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    checks++; if (pin_correct !== 1'b0) begin errors++; $display("FAIL reset_pin_correct: got %b want 0", pin_correct); end
    checks++; if (balance_ok !== 1'b0) begin errors++; $display("FAIL reset_balance_ok: got %b want 0", balance_ok); end
    checks++; if (card_locked !== 1'b0) begin errors++; $display("FAIL reset_card_locked: got %b want 0", card_locked); end
    checks++; if (amount_reject !== 1'b0) begin errors++; $display("FAIL reset_amount_reject: got %b want 0", amount_reject); end
    checks++; if (balance !== 16'd1000) begin errors++; $display("FAIL reset_balance: got %0d want 1000", balance); end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_withdrawal();
    card_inserted = 1'b1;
    step();
    send_digit(4'd1);
    send_digit(4'd2);
    send_digit(4'd3);
    checks++; if (pin_correct !== 1'b0) begin errors++; $display("FAIL wd_pin_early: got %b want 0", pin_correct); end
    send_digit(4'd4);
    checks++; if (pin_correct !== 1'b1) begin errors++; $display("FAIL wd_pin_after_4: got %b want 1", pin_correct); end
    checks++; if (balance_ok !== 1'b0) begin errors++; $display("FAIL wd_bal_ok_early: got %b want 0", balance_ok); end
    send_amount(16'd300);
    checks++; if (balance_ok !== 1'b1) begin errors++; $display("FAIL wd_bal_ok: got %b want 1", balance_ok); end
    dispense_cash = 1'b1;
    step();
    dispense_cash = 1'b0;
    checks++; if (balance !== 16'd700) begin errors++; $display("FAIL wd_balance: got %0d want 700", balance); end
    checks++; if (pin_correct !== 1'b0 || balance_ok !== 1'b0) begin errors++; $display("FAIL wd_flags_clear: got %b%b want 00", pin_correct, balance_ok); end
    card_inserted = 1'b0;
    step();
    step();
  endtask

  task automatic test_invalid_digit();
    card_inserted = 1'b1;
    step();
    send_digit(4'd1);
    send_digit(4'hA);
    send_digit(4'd2);
    send_digit(4'd3);
    checks++; if (pin_correct !== 1'b0) begin errors++; $display("FAIL inv_pin_early: got %b want 0", pin_correct); end
    send_digit(4'd4);
    checks++; if (pin_correct !== 1'b1) begin errors++; $display("FAIL inv_pin_after_4: got %b want 1", pin_correct); end
    card_inserted = 1'b0;
    step();
    checks++; if (pin_correct !== 1'b0) begin errors++; $display("FAIL inv_card_out: got %b want 0", pin_correct); end
  endtask

  task automatic test_reject();
    apply_reset();
    enter_pin(16'h1234);
    send_amount(16'd1001);
    checks++; if (amount_reject !== 1'b1) begin errors++; $display("FAIL rej_over_pulse: got %b want 1", amount_reject); end
    checks++; if (balance_ok !== 1'b0 || pin_correct !== 1'b1) begin errors++; $display("FAIL rej_state: got ok=%b pin=%b want ok=0 pin=1", balance_ok, pin_correct); end
    step();
    checks++; if (amount_reject !== 1'b0) begin errors++; $display("FAIL rej_one_cycle: got %b want 0", amount_reject); end
    send_amount(16'd0);
    checks++; if (amount_reject !== 1'b1 || balance_ok !== 1'b0) begin errors++; $display("FAIL rej_zero: got rej=%b ok=%b want rej=1 ok=0", amount_reject, balance_ok); end
    send_amount(16'd1000);
    checks++; if (balance_ok !== 1'b1 || amount_reject !== 1'b0) begin errors++; $display("FAIL rej_full_ok: got ok=%b rej=%b want ok=1 rej=0", balance_ok, amount_reject); end
    send_amount(16'd5);
    checks++; if (balance_ok !== 1'b1) begin errors++; $display("FAIL rej_frozen_ok: got %b want 1", balance_ok); end
    dispense_cash = 1'b1;
    step();
    dispense_cash = 1'b0;
    checks++; if (balance !== 16'd0) begin errors++; $display("FAIL rej_balance_zero: got %0d want 0", balance); end
    card_inserted = 1'b0;
    step();
  endtask

  task automatic test_card_drop();
    apply_reset();
    enter_pin(16'h1234);
    dispense_cash = 1'b1;
    step();
    dispense_cash = 1'b0;
    checks++; if (balance !== 16'd1000) begin errors++; $display("FAIL drop_dispense_in_pin_ok: got %0d want 1000", balance); end
    send_amount(16'd100);
    card_inserted = 1'b0;
    dispense_cash = 1'b1;
    step();
    dispense_cash = 1'b0;
    checks++; if (balance !== 16'd900) begin errors++; $display("FAIL drop_with_dispense: got %0d want 900", balance); end
    checks++; if (balance_ok !== 1'b0 || pin_correct !== 1'b0) begin errors++; $display("FAIL drop_idle_flags: got %b%b want 00", pin_correct, balance_ok); end
    enter_pin(16'h1234);
    send_amount(16'd200);
    card_inserted = 1'b0;
    step();
    checks++; if (balance !== 16'd900) begin errors++; $display("FAIL drop_no_debit: got %0d want 900", balance); end
    checks++; if (balance_ok !== 1'b0) begin errors++; $display("FAIL drop_alone_ok: got %b want 0", balance_ok); end
  endtask

  task automatic test_async_reset();
    enter_pin(16'h1234);
    send_amount(16'd50);
    checks++; if (balance_ok !== 1'b1) begin errors++; $display("FAIL ar_pre_ok: got %b want 1", balance_ok); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (balance_ok !== 1'b0 || pin_correct !== 1'b0) begin errors++; $display("FAIL ar_flags: got %b%b want 00", pin_correct, balance_ok); end
    checks++; if (balance !== 16'd1000) begin errors++; $display("FAIL ar_balance: got %0d want 1000", balance); end
    card_inserted = 1'b0;
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_lockout();
    apply_reset();
    enter_pin(16'h9999);
    card_inserted = 1'b0;
    step();
    enter_pin(16'h9999);
    checks++; if (card_locked !== 1'b0) begin errors++; $display("FAIL lock_early: got %b want 0", card_locked); end
    card_inserted = 1'b0;
    step();
    enter_pin(16'h1234);
    checks++; if (pin_correct !== 1'b1) begin errors++; $display("FAIL lock_good_pin: got %b want 1", pin_correct); end
    card_inserted = 1'b0;
    step();
    enter_pin(16'h9999);
    card_inserted = 1'b0;
    step();
    enter_pin(16'h9999);
    checks++; if (card_locked !== 1'b0) begin errors++; $display("FAIL lock_counter_cleared: got %b want 0", card_locked); end
    card_inserted = 1'b0;
    step();
    enter_pin(16'h9999);
    checks++; if (card_locked !== 1'b1) begin errors++; $display("FAIL lock_third: got %b want 1", card_locked); end
    card_inserted = 1'b0;
    step();
    enter_pin(16'h1234);
    checks++; if (card_locked !== 1'b1 || pin_correct !== 1'b0) begin errors++; $display("FAIL lock_sticky: got lock=%b pin=%b want lock=1 pin=0", card_locked, pin_correct); end
    apply_reset();
    checks++; if (card_locked !== 1'b0) begin errors++; $display("FAIL lock_reset: got %b want 0", card_locked); end
  endtask

  initial begin
    test_reset();
    test_withdrawal();
    test_invalid_digit();
    test_reject();
    test_card_drop();
    test_async_reset();
    test_lockout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/atm_auth_responder.md
ATM_AUTH_RESPONDER -- requirements
Module: atm_auth_responder

Interface
REQ-001 Parameter PIN_CODE, 16'h1234, stored PIN as four BCD digits, first-entered digit in [15:12].
REQ-002 Parameter INIT_BALANCE, 16'd1000, account balance loaded at reset.
REQ-003 Parameter MAX_TRIES, 2'd3, consecutive wrong PIN entries that lock the account.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 card_inserted  input  1  card present in reader.
REQ-007 digit_valid  input  1  one-cycle strobe qualifying digit.
REQ-008 digit  input  4  PIN digit; valid range 0..9.
REQ-009 amount_valid  input  1  one-cycle strobe qualifying amount.
REQ-010 amount  input  16  requested withdrawal, unsigned.
REQ-011 dispense_cash  input  1  controller strobe: cash dispensed, commit debit.
REQ-012 pin_correct  output  1  PIN verified for current session.
REQ-013 balance_ok  output  1  requested amount approved.
REQ-014 card_locked  output  1  account locked after MAX_TRIES failures.
REQ-015 amount_reject  output  1  one-cycle pulse: amount zero or above balance.
REQ-016 balance  output  16  current account balance.

Function
REQ-017 States SHALL be IDLE, PIN_ENTRY, PIN_OK, AMT_OK, LOCKED; all outputs registered.
REQ-018 pin_correct SHALL be 1 exactly in PIN_OK and AMT_OK; balance_ok exactly in AMT_OK; card_locked exactly in LOCKED.
REQ-019 IDLE: card_inserted=1 -> PIN_ENTRY next cycle, digit count cleared, PIN shift register cleared.
REQ-020 PIN_ENTRY: digit_valid with digit<=9 shifts digit into 16-bit register (left shift 4), count+1; digit>9 ignored, count unchanged.
REQ-021 On 4th accepted digit (cycle N), compare with PIN_CODE: match -> PIN_OK at N+1 (pin_correct high at N+1), fail counter cleared.
REQ-022 Mismatch -> fail counter+1; if new value = MAX_TRIES -> LOCKED at N+1; else stay PIN_ENTRY with count and register cleared.
REQ-023 Fail counter SHALL persist across card removal; cleared only by correct PIN or reset.
REQ-024 PIN_OK: amount_valid with 0 < amount <= balance -> latch amount, AMT_OK next cycle.
REQ-025 PIN_OK: amount_valid with amount=0 or amount>balance -> amount_reject pulse next cycle, stay PIN_OK.
REQ-026 AMT_OK: dispense_cash=1 -> balance <= balance - latched amount, IDLE next cycle; balance SHALL never underflow.
REQ-027 card_inserted=0 in PIN_ENTRY, PIN_OK, AMT_OK (without dispense_cash) -> IDLE next cycle, no debit.
REQ-028 Simultaneous dispense_cash and card_inserted=0 in AMT_OK: debit SHALL be committed, then IDLE.
REQ-029 digit_valid outside PIN_ENTRY, amount_valid outside PIN_OK, dispense_cash outside AMT_OK SHALL be ignored.
REQ-030 LOCKED is sticky regardless of card_inserted; exit only via reset.
REQ-031 Approved amount SHALL be frozen in AMT_OK; further amount_valid ignored.

Reset
REQ-032 rst_n low SHALL immediately force IDLE, pin_correct=0, balance_ok=0, card_locked=0, amount_reject=0, fail counter=0, digit count=0, balance=INIT_BALANCE.
REQ-033 Reset mid-session (any state, including AMT_OK) SHALL discard pending amount without debit.
REQ-034 First state change SHALL occur on the first rising clk edge after rst_n deasserts.

Verification
REQ-035 Insert card, digits 1,2,3,4, amount 300, dispense_cash -> pin_correct 1 cycle after digit 4, balance_ok 1 cycle after amount, balance 700 after dispense, both flags 0.
REQ-036 Three sessions of digits 9,9,9,9 (card removed between) -> card_locked=1 after 3rd, further correct PIN ignored, lock held until rst_n.
REQ-037 Correct PIN, amount 1001 with balance 1000 -> amount_reject pulse, balance_ok 0, state PIN_OK; then amount 1000 -> balance_ok 1, dispense -> balance 0.
REQ-038 Digits 1,A,2,3,4 -> A ignored, pin_correct asserted after digit 4.
REQ-039 In AMT_OK drop card_inserted with dispense_cash same cycle -> debit applied; drop card alone -> IDLE, balance unchanged.
REQ-040 Assert rst_n low while in AMT_OK -> outputs cleared asynchronously, balance=INIT_BALANCE.
